bit_unstuffer: RTL and testbench

Receive-side bit destuffer for the USB transceiver. It sits between the NRZI decoder and the receive shift/deserialiser. It removes the zero bit that the transmit-side bit stuffer inserts after six consecutive ones. A one in the stuff position is flagged as a bit-stuff error, and the error is held until the packet ends. Data bits pass through with one cycle of latency; stripped bits produce no output strobe.

---
 rtl/bit_unstuffer.sv | 100 ++++++++++
 tb/tb_bit_unstuffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bit_unstuffer.sv
// bit_unstuffer: receive-side USB bit destuffer.
// Drops the zero inserted after MAX_ONES consecutive ones, passes data bits
// through with one cycle of latency, and flags a one in the stuff slot as a
// sticky stuff error that holds until the packet ends.
module bit_unstuffer #(
  parameter int MAX_ONES = 6
) (
  input  logic clk,
  input  logic nRST,
  input  logic in_bit,
  input  logic in_valid,
  input  logic unstuff_en,
  output logic out_bit,
  output logic out_valid,
  output logic strip,
  output logic stuff_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DROP  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [2:0] LAST_ONE = 3'(MAX_ONES - 1);

  state_t     state, state_n;
  logic [2:0] ones_cnt, ones_cnt_n;
  logic [2:0] run_cnt;
  logic       out_bit_n, out_valid_n, strip_n, stuff_err_n;

  // IDLE behaves as COUNT with an empty run so the first packet bit is kept.
  assign run_cnt = (state == IDLE) ? 3'd0 : ones_cnt;

  // State, run counter and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      ones_cnt  <= 3'd0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      strip     <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      state     <= state_n;
      ones_cnt  <= ones_cnt_n;
      out_bit   <= out_bit_n;
      out_valid <= out_valid_n;
      strip     <= strip_n;
      stuff_err <= stuff_err_n;
    end
  end

  // Next-state and next-output decode; packet end overrides everything.
  always_comb begin
    state_n     = state;
    ones_cnt_n  = ones_cnt;
    out_bit_n   = out_bit;
    out_valid_n = 1'b0;
    strip_n     = 1'b0;
    stuff_err_n = stuff_err;

    if (!unstuff_en) begin
      state_n     = IDLE;
      ones_cnt_n  = 3'd0;
      stuff_err_n = 1'b0;
    end else if (in_valid) begin
      unique case (state)
        IDLE, COUNT: begin
          out_bit_n   = in_bit;
          out_valid_n = 1'b1;
          state_n     = COUNT;
          if (!in_bit) begin
            ones_cnt_n = 3'd0;
          end else if (run_cnt == LAST_ONE) begin
            ones_cnt_n = 3'd0;
            state_n    = DROP;
          end else begin
            ones_cnt_n = run_cnt + 3'd1;
          end
        end
        DROP: begin
          if (!in_bit) begin
            strip_n = 1'b1;
            state_n = COUNT;
          end else begin
            stuff_err_n = 1'b1;
            state_n     = ERROR;
          end
        end
        ERROR: begin
          // Discard everything until the packet ends.
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_unstuffer.sv
// tb_bit_unstuffer: scoreboard bench for bit_unstuffer (MAX_ONES=6).
// Stimulus pushes expected output events (data bit or strip pulse, with the
// cycle they must appear in); a negedge monitor pops and compares them.
module tb_bit_unstuffer;

  logic clk, nRST, in_bit, in_valid, unstuff_en;
  logic out_bit, out_valid, strip, stuff_err;

  typedef struct {
    bit is_strip;
    bit b;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   tests;
  int   fails;

  bit_unstuffer #(.MAX_ONES(6)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .unstuff_en(unstuff_en),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .strip     (strip),
    .stuff_err (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected outputs.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (nRST) begin
      if (out_valid && strip) begin
        tests++;
        fails++;
        $display("FAIL out_valid_and_strip cyc=%0d both high, required at most one", cyc);
      end else if (out_valid || strip) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output cyc=%0d out_valid=%0b strip=%0b, required none",
                   cyc, out_valid, strip);
        end else begin
          e = q.pop_front();
          if (e.is_strip != strip || e.cyc != cyc || (!e.is_strip && e.b != out_bit)) begin
            fails++;
            $display("FAIL output_event got strip=%0b bit=%0b cyc=%0d, required strip=%0b bit=%0b cyc=%0d",
                     strip, out_bit, cyc, e.is_strip, e.b, e.cyc);
          end
        end
      end
    end
  end

  // Drive one bit strobe; exp=1 queues the expected output event.
  task automatic send(input bit b, input bit exp, input bit is_strip);
    exp_t e;
    in_bit   = b;
    in_valid = 1'b1;
    if (exp) begin
      e.is_strip = is_strip;
      e.b        = b;
      e.cyc      = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0b, required %0b", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    exp_t       dummy;
    cyc        = 0;
    tests      = 0;
    fails      = 0;
    nRST       = 1'b0;
    in_bit     = 1'b0;
    in_valid   = 1'b0;
    unstuff_en = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_bit",   out_bit,   1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_strip",     strip,     1'b0);
    chk("reset_stuff_err", stuff_err, 1'b0);
    nRST = 1'b1;
    idle(2);
    unstuff_en = 1'b1;

    // Plain data, MSB first.
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) send(pat[i], 1'b1, 1'b0);
    idle(2);
    chk("plain_no_err", stuff_err, 1'b0);

    // Stuffed run: six ones, stuff zero, then 1,0.
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("stuffed_no_err", stuff_err, 1'b0);

    // Stuff error: seventh one sits in the stuff slot.
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b0);
    chk("err_before_7th", stuff_err, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    chk("err_after_7th", stuff_err, 1'b1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    idle(3);
    chk("err_sticky", stuff_err, 1'b1);
    unstuff_en = 1'b0;
    idle(1);
    chk("err_cleared", stuff_err, 1'b0);
    unstuff_en = 1'b1;
    idle(1);

    // Gapped strobes: DROP must survive long gaps.
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1, 1'b0);
      idle(3);
    end
    idle(10);
    send(1'b0, 1'b1, 1'b1);
    idle(2);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b0);
    idle(2);
    send(1'b0, 1'b1, 1'b1);
    idle(2);
    chk("gapped_no_err", stuff_err, 1'b0);

    // Packet boundary: counter cleared; the bit on the falling edge is dropped.
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 1'b0);
    unstuff_en = 1'b0;
    send(1'b1, 1'b0, 1'b0);
    unstuff_en = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("boundary_no_err", stuff_err, 1'b0);

    // Async reset mid-run, between clock edges.
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1 nRST = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_bit",   out_bit,   1'b0);
    // The fourth bit's output was cut short by reset before the monitor saw it.
    dummy = q.pop_back();
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    idle(3);
    chk("post_reset_no_err", stuff_err, 1'b0);

    // Every queued event must have been seen.
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drained got %0d pending, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
